keypad_scanner: RTL

Front end of the keypad input path. Drives the 4x4 matrix rows one at a time and samples the columns through a synchronizer. It debounces press and release over whole scan frames. For each clean, single-key press it emits a one-cycle strobe plus a row/column one-hot key code. That code feeds the downstream letter-selection FSM on its strobe/cur_key inputs.

---
 rtl/keypad_scanner_pkg.sv | 34 +++
 rtl/keypad_scanner_if.sv | 29 ++
 rtl/keypad_scanner_row_scanner.sv | 100 ++++++++++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and key-code constants for the keypad front end and the
// downstream letter-selection FSM.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    HELD,
    RELEASE
  } scan_state_t;

  localparam logic [7:0] NO_KEY     = 8'h00;
  localparam logic [7:0] MULTI_KEY  = 8'hFF;
  localparam logic [3:0] ROW0_DRIVE = 4'b1000;

  // Bottom-row function keys consumed by the letter-selection FSM
  localparam logic [7:0] KEY_CLEAR         = 8'b0001_1000;
  localparam logic [7:0] KEY_BACKSPACE     = 8'b0001_0100;
  localparam logic [7:0] KEY_SUBMIT_LETTER = 8'b0001_0010;
  localparam logic [7:0] KEY_SUBMIT_WORD   = 8'b0001_0001;

  function automatic logic [7:0] make_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = ROW0_DRIVE >> row;
    c = 4'b1000 >> col;
    return {r, c};
  endfunction

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix lines and key-event outputs of the keypad scanner.
interface keypad_scanner_if;

  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       strobe;
  logic [7:0] key_code;
  logic       key_held;
  logic       multi_key;

  modport master (
    input  col_in,
    output row_out,
    output strobe,
    output key_code,
    output key_held,
    output multi_key
  );

  modport slave (
    output col_in,
    input  row_out,
    input  strobe,
    input  key_code,
    input  key_held,
    input  multi_key
  );

endinterface

// File: rtl/keypad_scanner_row_scanner.sv
// Row driver, column synchronizer and per-frame accumulation: reduces one
// full matrix sweep to a single frame_key (a key, NO_KEY or MULTI_KEY).
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       frame_done,
  output logic [7:0] frame_key,
  output logic       frame_multi
);

  localparam int SLOT_W = $clog2(SCAN_CYCLES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SCAN_CYCLES - 1);

  logic [3:0]        col_meta;
  logic [3:0]        col_sync;
  logic [SLOT_W-1:0] slot;
  logic              sample_now;
  logic              frame_end;
  logic [2:0]        ones;
  logic              hit;
  logic              multi;
  logic [7:0]        cand;
  logic              hit_n;
  logic              multi_n;
  logic [7:0]        cand_n;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      slot    <= '0;
      row_out <= ROW0_DRIVE;
    end else if (sample_now) begin
      slot    <= '0;
      row_out <= {row_out[0], row_out[3:1]};
    end else begin
      slot    <= slot + SLOT_W'(1);
    end
  end

  // Sample is folded in against the row still being driven; R3 closes the frame
  always_comb begin
    sample_now = (slot == LAST_SLOT);
    frame_end  = sample_now && (row_out == 4'b0001);
    ones       = count_ones(col_sync);
    hit_n      = hit;
    multi_n    = multi;
    cand_n     = cand;
    if (sample_now) begin
      if ((ones == 3'd1) && !hit) begin
        cand_n = {row_out, col_sync};
      end
      if ((ones >= 3'd2) || ((ones != 3'd0) && hit)) begin
        multi_n = 1'b1;
      end
      if (ones != 3'd0) begin
        hit_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hit         <= 1'b0;
      multi       <= 1'b0;
      cand        <= NO_KEY;
      frame_done  <= 1'b0;
      frame_key   <= NO_KEY;
      frame_multi <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_key   <= multi_n ? MULTI_KEY : (hit_n ? cand_n : NO_KEY);
        frame_multi <= multi_n;
        hit         <= 1'b0;
        multi       <= 1'b0;
        cand        <= NO_KEY;
      end else begin
        hit   <= hit_n;
        multi <= multi_n;
        cand  <= cand_n;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner top: frame-level press/release debounce producing a
// one-cycle strobe and a held one-hot key code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              nRst,
  keypad_scanner_if.master  kp
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic              frame_done;
  logic [7:0]        frame_key;
  logic              frame_multi;
  scan_state_t       state;
  scan_state_t       state_n;
  logic [7:0]        cand;
  logic [7:0]        cand_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              is_key;
  logic              accept;
  logic              release_done;

  keypad_row_scanner #(
    .SCAN_CYCLES (SCAN_CYCLES)
  ) u_rows (
    .clk         (clk),
    .nRst        (nRst),
    .col_in      (kp.col_in),
    .row_out     (kp.row_out),
    .frame_done  (frame_done),
    .frame_key   (frame_key),
    .frame_multi (frame_multi)
  );

  assign kp.multi_key = frame_done & frame_multi;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      cand  <= NO_KEY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    cand_n       = cand;
    cnt_n        = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    is_key       = (frame_key != NO_KEY) && (frame_key != MULTI_KEY);
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (is_key) begin
            cand_n = frame_key;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = CHECK;
            end
          end
        end
        CHECK: begin
          if (frame_key == cand) begin
            if (cnt == CNT_LAST) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else begin
            state_n = IDLE;
          end
        end
        // Anything but an empty frame keeps the key held, so no auto-repeat
        HELD: begin
          if (frame_key == NO_KEY) begin
            cnt_n = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              release_done = 1'b1;
              state_n      = IDLE;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (frame_key == NO_KEY) begin
            if (cnt == CNT_LAST) begin
              release_done = 1'b1;
              state_n      = IDLE;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      kp.strobe   <= 1'b0;
      kp.key_code <= NO_KEY;
      kp.key_held <= 1'b0;
    end else begin
      kp.strobe <= accept;
      if (accept) begin
        kp.key_code <= cand_n;
        kp.key_held <= 1'b1;
      end else if (release_done) begin
        kp.key_held <= 1'b0;
      end
    end
  end

endmodule
